// File: rtl/multicycle_control_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_fsm_pkg
// Description : Shared definitions for the multi-cycle RV32I control sequencer:
//               state encodings, RV32I major opcodes, ALU operation codes,
//               PC source codes, ALU B-operand codes and the packed control
//               vector that the decoder produces each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_control_fsm_pkg;

    // Sequencer states; the encoding is visible on the debug state port.
    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    // RV32I major opcodes (IR[6:0]), matching opcodes.v.
    localparam logic [6:0] c_OP_ARITH     = 7'b0110011;
    localparam logic [6:0] c_OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD      = 7'b0000011;
    localparam logic [6:0] c_OP_STORE     = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] c_OP_JAL       = 7'b1101111;
    localparam logic [6:0] c_OP_JALR      = 7'b1100111;
    localparam logic [6:0] c_OP_ECALL     = 7'b1110011;

    // ALU operation selects.
    localparam logic [1:0] c_ALU_ADD      = 2'b00;
    localparam logic [1:0] c_ALU_BRANCH   = 2'b01;
    localparam logic [1:0] c_ALU_FUNCT    = 2'b10;

    // PC source selects.
    localparam logic [1:0] c_PC_SRC_PC4    = 2'b00;
    localparam logic [1:0] c_PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PC_SRC_ALU    = 2'b10;

    // ALU B-operand selects.
    localparam logic [1:0] c_SRC_B_RS2    = 2'b00;
    localparam logic [1:0] c_SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] c_SRC_B_IMM    = 2'b10;

    // Every datapath enable and select driven by the sequencer.
    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       pc_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       is_ecall;
        logic       is_halted;
    } ctrl_t;

    // All enables off, all selects zero.
    localparam ctrl_t c_CTRL_IDLE = '0;

endpackage : multicycle_control_fsm_pkg
`default_nettype wire

// File: rtl/mcfsm_decode.sv
`default_nettype none
// ============================================================================
// Module      : mcfsm_decode
// Description : Purely combinational next-state and control-output map for
//               the multi-cycle control sequencer.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   state      in   current sequencer state
//   opcode     in   IR[6:0]
//   bcond      in   ALU branch-taken flag (used in EX for BRANCH)
//   halt_req   in   halt condition for ECALL (used in ID)
//   mem_ready  in   memory completed the current request (used in IF/MEM)
//   next_state out  state to load on the next rising edge
//   ctrl       out  control vector for the current cycle
// ============================================================================
module mcfsm_decode
    import multicycle_control_fsm_pkg::*;
(
    input  state_t     state,
    input  logic [6:0] opcode,
    input  logic       bcond,
    input  logic       halt_req,
    input  logic       mem_ready,
    output state_t     next_state,
    output ctrl_t      ctrl
);

    state_t w_next_state;
    ctrl_t  w_ctrl;

    always_comb begin
        w_next_state = state;
        w_ctrl       = c_CTRL_IDLE;

        case (state)
            ST_IF: begin
                // Request and address are held until mem_ready; the IR
                // loads only in the completing cycle.
                w_ctrl.mem_read = 1'b1;
                w_ctrl.iord     = 1'b0;
                w_ctrl.ir_write = mem_ready;
                if (mem_ready) begin
                    w_next_state = ST_ID;
                end
            end

            ST_ID: begin
                // ALUOut captures PC+imm, the target for BRANCH and JAL.
                w_ctrl.alu_src_a = 1'b0;
                w_ctrl.alu_src_b = c_SRC_B_IMM;
                w_ctrl.alu_op    = c_ALU_ADD;
                if (opcode == c_OP_ECALL) begin
                    w_ctrl.is_ecall = 1'b1;
                    if (halt_req) begin
                        w_next_state = ST_HALT;
                    end else begin
                        w_ctrl.pc_write  = 1'b1;
                        w_ctrl.pc_source = c_PC_SRC_PC4;
                        w_next_state     = ST_IF;
                    end
                end else begin
                    w_next_state = ST_EX;
                end
            end

            ST_EX: begin
                case (opcode)
                    c_OP_ARITH: begin
                        w_ctrl.alu_src_a = 1'b1;
                        w_ctrl.alu_src_b = c_SRC_B_RS2;
                        w_ctrl.alu_op    = c_ALU_FUNCT;
                        w_next_state     = ST_WB;
                    end
                    c_OP_ARITH_IMM: begin
                        w_ctrl.alu_src_a = 1'b1;
                        w_ctrl.alu_src_b = c_SRC_B_IMM;
                        w_ctrl.alu_op    = c_ALU_FUNCT;
                        w_next_state     = ST_WB;
                    end
                    c_OP_LOAD, c_OP_STORE: begin
                        w_ctrl.alu_src_a = 1'b1;
                        w_ctrl.alu_src_b = c_SRC_B_IMM;
                        w_ctrl.alu_op    = c_ALU_ADD;
                        w_next_state     = ST_MEM;
                    end
                    c_OP_BRANCH: begin
                        // The ALU compares rs1/rs2 while ALUOut still holds
                        // the target computed in ID.
                        w_ctrl.alu_src_a = 1'b1;
                        w_ctrl.alu_src_b = c_SRC_B_RS2;
                        w_ctrl.alu_op    = c_ALU_BRANCH;
                        w_ctrl.pc_write  = 1'b1;
                        w_ctrl.pc_source = bcond ? c_PC_SRC_ALUOUT : c_PC_SRC_PC4;
                        w_next_state     = ST_IF;
                    end
                    c_OP_JAL: begin
                        // Link value PC+4 comes from the pre-update PC; both
                        // writes commit on the same edge.
                        w_ctrl.pc_write  = 1'b1;
                        w_ctrl.pc_source = c_PC_SRC_ALUOUT;
                        w_ctrl.reg_write = 1'b1;
                        w_ctrl.pc_to_reg = 1'b1;
                        w_next_state     = ST_IF;
                    end
                    c_OP_JALR: begin
                        w_ctrl.alu_src_a = 1'b1;
                        w_ctrl.alu_src_b = c_SRC_B_IMM;
                        w_ctrl.alu_op    = c_ALU_ADD;
                        w_ctrl.pc_write  = 1'b1;
                        w_ctrl.pc_source = c_PC_SRC_ALU;
                        w_ctrl.reg_write = 1'b1;
                        w_ctrl.pc_to_reg = 1'b1;
                        w_next_state     = ST_IF;
                    end
                    default: begin
                        // Unknown opcode retires as a NOP.
                        w_ctrl.pc_write  = 1'b1;
                        w_ctrl.pc_source = c_PC_SRC_PC4;
                        w_next_state     = ST_IF;
                    end
                endcase
            end

            ST_MEM: begin
                // Address operands stay selected so ALUOut is stable.
                w_ctrl.iord      = 1'b1;
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = c_SRC_B_IMM;
                if (opcode == c_OP_LOAD) begin
                    w_ctrl.mem_read = 1'b1;
                    if (mem_ready) begin
                        w_next_state = ST_WB;
                    end
                end else if (opcode == c_OP_STORE) begin
                    w_ctrl.mem_write = 1'b1;
                    if (mem_ready) begin
                        w_ctrl.pc_write  = 1'b1;
                        w_ctrl.pc_source = c_PC_SRC_PC4;
                        w_next_state     = ST_IF;
                    end
                end else begin
                    // Only reachable if opcode changed after ID; retire
                    // without touching memory rather than hanging.
                    w_ctrl.pc_write  = 1'b1;
                    w_ctrl.pc_source = c_PC_SRC_PC4;
                    w_next_state     = ST_IF;
                end
            end

            ST_WB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = (opcode == c_OP_LOAD);
                w_ctrl.pc_write   = 1'b1;
                w_ctrl.pc_source  = c_PC_SRC_PC4;
                w_next_state      = ST_IF;
            end

            ST_HALT: begin
                // Absorbing; only reset leaves.
                w_ctrl.is_halted = 1'b1;
                w_next_state     = ST_HALT;
            end

            default: begin
                // Unused encodings recover to fetch.
                w_next_state = ST_IF;
            end
        endcase
    end

    assign next_state = w_next_state;
    assign ctrl       = w_ctrl;

endmodule : mcfsm_decode
`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_fsm
// Description : Control sequencer for the multi-cycle RV32I core. Walks each
//               instruction through IF/ID/EX/MEM/WB, stalls on memory ready,
//               and drives every datapath enable and select per state.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   core clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   opcode     in   IR[6:0]
//   bcond      in   ALU branch-taken flag
//   halt_req   in   ECALL halt condition (x17==10)
//   mem_ready  in   memory completed current request
//   pc_write .. alu_op   out  datapath enables and selects
//   is_ecall   out  ECALL being decoded
//   is_halted  out  core halted
//   state      out  current state (debug)
// ============================================================================
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] opcode,
    input  logic       bcond,
    input  logic       halt_req,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       pc_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       is_ecall,
    output logic       is_halted,
    output logic [2:0] state
);

    state_t r_state;
    state_t w_next_state;
    ctrl_t  w_ctrl;
    ctrl_t  w_ctrl_gated;

    mcfsm_decode u_decode (
        .state      (r_state),
        .opcode     (opcode),
        .bcond      (bcond),
        .halt_req   (halt_req),
        .mem_ready  (mem_ready),
        .next_state (w_next_state),
        .ctrl       (w_ctrl)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IF;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The state register alone would leave IF's fetch request visible during
    // reset; gate the whole vector so nothing commits while reset_n is low.
    assign w_ctrl_gated = reset_n ? w_ctrl : c_CTRL_IDLE;

    assign pc_write   = w_ctrl_gated.pc_write;
    assign pc_source  = w_ctrl_gated.pc_source;
    assign iord       = w_ctrl_gated.iord;
    assign mem_read   = w_ctrl_gated.mem_read;
    assign mem_write  = w_ctrl_gated.mem_write;
    assign ir_write   = w_ctrl_gated.ir_write;
    assign mem_to_reg = w_ctrl_gated.mem_to_reg;
    assign pc_to_reg  = w_ctrl_gated.pc_to_reg;
    assign reg_write  = w_ctrl_gated.reg_write;
    assign alu_src_a  = w_ctrl_gated.alu_src_a;
    assign alu_src_b  = w_ctrl_gated.alu_src_b;
    assign alu_op     = w_ctrl_gated.alu_op;
    assign is_ecall   = w_ctrl_gated.is_ecall;
    assign is_halted  = w_ctrl_gated.is_halted;
    assign state      = r_state;

endmodule : multicycle_control_fsm
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_fsm
// Description : Directed self-checking bench for multicycle_control_fsm.
//               Each cycle compares the full output vector against a
//               hand-derived expectation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_fsm;

    logic       clk;
    logic       reset_n;
    logic [6:0] opcode;
    logic       bcond;
    logic       halt_req;
    logic       mem_ready;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       pc_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       is_ecall;
    logic       is_halted;
    logic [2:0] state;

    int n_vec;
    int n_err;

    multicycle_control_fsm dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .opcode     (opcode),
        .bcond      (bcond),
        .halt_req   (halt_req),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .pc_source  (pc_source),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .mem_to_reg (mem_to_reg),
        .pc_to_reg  (pc_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .is_ecall   (is_ecall),
        .is_halted  (is_halted),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    // Observed vector: {state, pc_write, pc_source, iord, mem_read,
    // mem_write, ir_write, mem_to_reg, pc_to_reg, reg_write, alu_src_a,
    // alu_src_b, alu_op, is_ecall, is_halted}
    logic [19:0] w_obs;
    assign w_obs = {state, pc_write, pc_source, iord, mem_read, mem_write,
                    ir_write, mem_to_reg, pc_to_reg, reg_write, alu_src_a,
                    alu_src_b, alu_op, is_ecall, is_halted};

    function automatic logic [19:0] mk(
        input int st, input int pcw, input int pcs, input int io,
        input int mr, input int mw, input int irw, input int m2r,
        input int p2r, input int rw, input int asa, input int asb,
        input int aop, input int ec, input int hl);
        return {st[2:0], pcw[0], pcs[1:0], io[0], mr[0], mw[0], irw[0],
                m2r[0], p2r[0], rw[0], asa[0], asb[1:0], aop[1:0], ec[0], hl[0]};
    endfunction

    //                   st pcw pcs io mr mw irw m2r p2r rw asa asb aop ec hl
    logic [19:0] E_RST, E_IF_W, E_IF_R, E_ID, E_ID_EC, E_ID_HLT, E_EX_R,
                 E_EX_I, E_EX_LS, E_EX_BT, E_EX_BN, E_EX_JAL, E_EX_JALR,
                 E_EX_NOP, E_MEM_LD, E_MEM_ST, E_MEM_STR, E_WB, E_WB_LD,
                 E_HALT;

    initial begin
        E_RST     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_IF_W    = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_IF_R    = mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        E_ID      = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
        E_ID_EC   = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0);
        E_ID_HLT  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0);
        E_EX_R    = mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0);
        E_EX_I    = mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 0, 0);
        E_EX_LS   = mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        E_EX_BT   = mk(2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        E_EX_BN   = mk(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        E_EX_JAL  = mk(2, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        E_EX_JALR = mk(2, 1, 2, 0, 0, 0, 0, 0, 1, 1, 1, 2, 0, 0, 0);
        E_EX_NOP  = mk(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_MEM_LD  = mk(3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        E_MEM_ST  = mk(3, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        E_MEM_STR = mk(3, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        E_WB      = mk(4, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        E_WB_LD   = mk(4, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        E_HALT    = mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    end

    task automatic check_vec(input string tag, input logic [19:0] got,
                             input logic [19:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at posedge+1: apply inputs, let outputs settle, compare, then
    // advance one clock.
    task automatic cyc(input string tag, input logic [6:0] op, input logic bc,
                       input logic hr, input logic rdy, input logic [19:0] exp);
        opcode    = op;
        bcond     = bc;
        halt_req  = hr;
        mem_ready = rdy;
        #1;
        check_vec(tag, w_obs, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset_n   = 1'b0;
        opcode    = OP_R;
        bcond     = 1'b0;
        halt_req  = 1'b0;
        mem_ready = 1'b1;

        // Reset holds IF with every enable gated, even with mem_ready high.
        #12;
        check_vec("reset", w_obs, E_RST);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // ADD, zero wait: 4 cycles.
        cyc("add_if",  OP_R, 0, 0, 1, E_IF_R);
        cyc("add_id",  OP_R, 0, 0, 1, E_ID);
        cyc("add_ex",  OP_R, 0, 0, 1, E_EX_R);
        cyc("add_wb",  OP_R, 0, 0, 1, E_WB);

        // ADDI, mem_ready low outside IF/MEM is ignored.
        cyc("addi_if", OP_I, 0, 0, 1, E_IF_R);
        cyc("addi_id", OP_I, 0, 0, 0, E_ID);
        cyc("addi_ex", OP_I, 0, 0, 0, E_EX_I);
        cyc("addi_wb", OP_I, 0, 0, 0, E_WB);

        // LW: 2 IF waits, 3 MEM waits -> 10 cycles.
        cyc("lw_if_w0",  OP_LD, 0, 0, 0, E_IF_W);
        cyc("lw_if_w1",  OP_LD, 0, 0, 0, E_IF_W);
        cyc("lw_if_rdy", OP_LD, 0, 0, 1, E_IF_R);
        cyc("lw_id",     OP_LD, 0, 0, 0, E_ID);
        cyc("lw_ex",     OP_LD, 0, 0, 0, E_EX_LS);
        cyc("lw_mem_w0", OP_LD, 0, 0, 0, E_MEM_LD);
        cyc("lw_mem_w1", OP_LD, 0, 0, 0, E_MEM_LD);
        cyc("lw_mem_w2", OP_LD, 0, 0, 0, E_MEM_LD);
        cyc("lw_mem_rd", OP_LD, 0, 0, 1, E_MEM_LD);
        cyc("lw_wb",     OP_LD, 0, 0, 1, E_WB_LD);

        // BEQ taken then not taken: 3 cycles each.
        cyc("beqt_if", OP_BR, 1, 0, 1, E_IF_R);
        cyc("beqt_id", OP_BR, 1, 0, 1, E_ID);
        cyc("beqt_ex", OP_BR, 1, 0, 1, E_EX_BT);
        cyc("beqn_if", OP_BR, 0, 0, 1, E_IF_R);
        cyc("beqn_id", OP_BR, 0, 0, 1, E_ID);
        cyc("beqn_ex", OP_BR, 0, 0, 1, E_EX_BN);

        // JAL, JALR.
        cyc("jal_if",   OP_JAL,  0, 0, 1, E_IF_R);
        cyc("jal_id",   OP_JAL,  0, 0, 1, E_ID);
        cyc("jal_ex",   OP_JAL,  0, 0, 1, E_EX_JAL);
        cyc("jalr_if",  OP_JALR, 0, 0, 1, E_IF_R);
        cyc("jalr_id",  OP_JALR, 0, 0, 1, E_ID);
        cyc("jalr_ex",  OP_JALR, 0, 0, 1, E_EX_JALR);

        // Unknown opcode retires as NOP.
        cyc("nop_if",  OP_BAD, 0, 0, 1, E_IF_R);
        cyc("nop_id",  OP_BAD, 0, 0, 1, E_ID);
        cyc("nop_ex",  OP_BAD, 0, 0, 1, E_EX_NOP);

        // SW zero wait: 4 cycles.
        cyc("sw_if",  OP_ST, 0, 0, 1, E_IF_R);
        cyc("sw_id",  OP_ST, 0, 0, 1, E_ID);
        cyc("sw_ex",  OP_ST, 0, 0, 1, E_EX_LS);
        cyc("sw_mem", OP_ST, 0, 0, 1, E_MEM_STR);

        // ECALL without halt: 2 cycles, PC advances in ID.
        cyc("ec_if", OP_SYS, 0, 0, 1, E_IF_R);
        cyc("ec_id", OP_SYS, 0, 0, 1, E_ID_EC);
        cyc("ec_next_if", OP_SYS, 0, 0, 0, E_IF_W);
        cyc("ec_next_if2", OP_SYS, 0, 0, 1, E_IF_R);

        // ECALL with halt: HALT absorbs for 20+ cycles regardless of inputs.
        cyc("hlt_id", OP_SYS, 0, 1, 1, E_ID_HLT);
        for (int i = 0; i < 22; i++) begin
            cyc("halt_hold", (i % 2 == 0) ? OP_LD : OP_JAL, i[0], 1, 1, E_HALT);
        end

        // Reset leaves HALT.
        reset_n = 1'b0;
        #1;
        check_vec("halt_reset", w_obs, E_RST);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // SW with async reset mid-MEM.
        cyc("swr_if",    OP_ST, 0, 0, 1, E_IF_R);
        cyc("swr_id",    OP_ST, 0, 0, 1, E_ID);
        cyc("swr_ex",    OP_ST, 0, 0, 1, E_EX_LS);
        cyc("swr_mem_w", OP_ST, 0, 0, 0, E_MEM_ST);
        mem_ready = 1'b0;
        #1;
        check_vec("swr_mem_w2", w_obs, E_MEM_ST);
        #2;
        reset_n = 1'b0;
        #1;
        check_vec("swr_async_rst", w_obs, E_RST);
        @(posedge clk);
        #1;
        check_vec("swr_rst_held", w_obs, E_RST);
        reset_n = 1'b1;
        cyc("swr_rel_if", OP_ST, 0, 0, 1, E_IF_R);
        cyc("swr_rel_id", OP_ST, 0, 0, 1, E_ID);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_multicycle_control_fsm
`default_nettype wire

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Control sequencer for the multi-cycle RV32I core. Each instruction walks through fetch, decode, execute, memory and write-back states. The block drives every datapath enable and mux select per state, and stalls on a ready handshake to the shared instruction/data memory. It replaces the single-cycle combinational decoder. It sits beside the datapath and reads only the IR opcode, the ALU branch condition, the ecall halt condition and memory ready.

## Interface
Parameters:
- None.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- opcode  in  7  IR[6:0]; codes from opcodes.v
- bcond  in  1  ALU branch-taken flag; valid in EX for BRANCH
- halt_req  in  1  datapath flag x17==10; valid in ID
- mem_ready  in  1  memory completed the current request this cycle
- pc_write  out  1  PC load enable
- pc_source  out  2  00 PC+4 adder, 01 ALUOut register, 10 ALU result (datapath clears bit 0)
- iord  out  1  memory address: 0 PC, 1 ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load enable
- mem_to_reg  out  1  register write data from MDR
- pc_to_reg  out  1  register write data from PC+4
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 PC, 1 rs1
- alu_src_b  out  2  00 rs2, 01 constant 4, 10 immediate
- alu_op  out  2  00 add, 01 branch compare, 10 funct-decoded
- is_ecall  out  1  ECALL being decoded
- is_halted  out  1  core halted
- state  out  3  current state, for debug

## Operation
- States: IF, ID, EX, MEM, WB, HALT.
- All outputs are combinational from state, opcode, bcond, halt_req and mem_ready. Outputs not listed for a state are 0.
- **IF:** mem_read=1, iord=0, ir_write=mem_ready. Go to ID when mem_ready=1, otherwise stay in IF.
- **ID:** alu_src_a=0, alu_src_b=10, alu_op=00, so ALUOut captures PC+imm.
  - ECALL: is_ecall=1. If halt_req=1, go to HALT. Otherwise pc_write=1 with pc_source=00, and go to IF.
  - Any other opcode: go to EX.
- **EX, ARITHMETIC:** alu_src_a=1, alu_src_b=00, alu_op=10; go to WB.
- **EX, ARITHMETIC_IMM:** as ARITHMETIC but alu_src_b=10; go to WB.
- **EX, LOAD/STORE:** alu_src_a=1, alu_src_b=10, alu_op=00; go to MEM.
- **EX, BRANCH:** alu_src_a=1, alu_src_b=00, alu_op=01, pc_write=1, pc_source = bcond ? 01 : 00; go to IF.
- **EX, JAL:** pc_write=1, pc_source=01, reg_write=1, pc_to_reg=1; go to IF.
- **EX, JALR:** alu_src_a=1, alu_src_b=10, alu_op=00, pc_write=1, pc_source=10, reg_write=1, pc_to_reg=1; go to IF.
- **EX, unknown opcode:** pc_write=1, pc_source=00, no other writes; go to IF (executes as a NOP).
- **MEM:** iord=1, alu_src_a=1, alu_src_b=10 (held).
  - LOAD: mem_read=1. On mem_ready, go to WB; the MDR latches unconditionally.
  - STORE: mem_write=1. On mem_ready, pc_write=1 with pc_source=00, and go to IF.
  - Without mem_ready: stay in MEM.
- **WB:** reg_write=1, mem_to_reg = (opcode==LOAD), pc_write=1, pc_source=00; go to IF.
- **HALT:** is_halted=1 and every enable is 0. HALT is absorbing; only reset leaves it.

## Timing
- Reset: while reset_n=0, state=IF and pc_write, ir_write, reg_write, mem_read and mem_write are forced to 0.
  - All selects and alu_op read 0.
  - is_ecall and is_halted read 0.
  - Reset asserted mid-instruction abandons the instruction; no partial register or PC write commits after the reset edge.
- First fetch request appears in the first cycle with reset_n=1.
- Memory handshake:
  - The request and address are held constant every cycle until the cycle with mem_ready=1. That cycle completes the transfer.
  - The request drops in the next cycle, because the state has changed.
  - mem_ready is ignored outside IF and MEM.
  - mem_ready may already be 1 in the first request cycle (zero wait).
- Cycles per instruction with zero wait: R/I-type 4, LOAD 5, STORE 4, BRANCH/JAL/JALR 3, ECALL 2. Each wait cycle adds 1, in IF or MEM.
- opcode must be stable from ID onward; the IR is written only in IF.
- The PC update and the register write of JAL/JALR commit on the same edge. PC+4 is taken from the pre-update PC.

## Structure
- Put these in a shared package/header next to opcodes.v:
  - state encodings: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5
  - alu_op codes
  - pc_source codes
  - alu_src_b codes
- One sub-module, mcfsm_decode: the purely combinational map from (state, opcode, bcond, halt_req, mem_ready) to next_state and the output vector.
- The top level holds only the async-reset state register and the reset gating.

## Test plan
- ADD x3,x1,x2 with mem_ready tied to 1 → states IF,ID,EX,WB; reg_write=1 only in WB; pc_write=1 only in WB with pc_source=00.
- LW with mem_ready low for 2 cycles in IF and 3 cycles in MEM → 10 cycles total. mem_read and iord stay constant across the waits, and mem_read is 0 in the cycle after mem_ready.
- BEQ with bcond=1, then with bcond=0 → EX asserts pc_write with pc_source=01 and 00 respectively; 3 cycles each.
- JALR → in EX, pc_source=10, reg_write=1 and pc_to_reg=1 in the same cycle; returns to IF.
- ECALL with halt_req=0, then ECALL with halt_req=1:
  - halt_req=0 → is_ecall pulses for 1 cycle in ID and the PC advances.
  - halt_req=1 → the FSM enters HALT, is_halted=1, all enables stay 0 for 20 or more cycles.
- Assert reset_n=0 asynchronously mid-MEM of a STORE → mem_write drops immediately and state=IF. After release, IF issues mem_read with iord=0.
